// File: rtl/magic_cube_pkg.sv
// Shared definitions for the magic cube sticker store: command and state
// encodings, default geometry and the colour code constants.
package magic_cube_pkg;

    localparam int FACES_DEF = 6;
    localparam int CELLS_DEF = 9;
    localparam int CW_DEF    = 3;

    typedef enum logic [1:0] {
        OP_WRITE     = 2'b00,
        OP_CLR_FACE  = 2'b01,
        OP_CLR_CUBE  = 2'b10,
        OP_FILL_FACE = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_UPDATE = 3'd2,
        ST_DONE   = 3'd3,
        ST_READY  = 3'd4
    } state_t;

    // Colour codes as produced by the colour classifier.
    localparam logic [CW_DEF-1:0] COL_NONE   = 3'd0;
    localparam logic [CW_DEF-1:0] COL_WHITE  = 3'd1;
    localparam logic [CW_DEF-1:0] COL_YELLOW = 3'd2;
    localparam logic [CW_DEF-1:0] COL_RED    = 3'd3;
    localparam logic [CW_DEF-1:0] COL_ORANGE = 3'd4;
    localparam logic [CW_DEF-1:0] COL_BLUE   = 3'd5;
    localparam logic [CW_DEF-1:0] COL_GREEN  = 3'd6;

endpackage

// File: rtl/magic_face_store.sv
// One cube face: CELLS colour registers with clear, fill and single-cell
// write controls. Clear has priority over fill, fill over cell write.
module magic_face_store
    import magic_cube_pkg::*;
#(
    parameter int CELLS = CELLS_DEF,
    parameter int CW    = CW_DEF,
    parameter int CIW   = (CELLS > 1) ? $clog2(CELLS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_cell,
    input  logic                  clr,
    input  logic                  fill,
    input  logic [CIW-1:0]        cell_idx,
    input  logic [CW-1:0]         color,
    output logic [CELLS*CW-1:0]   data
);

    genvar gi;
    generate
        for (gi = 0; gi < CELLS; gi++) begin : g_cell
            logic [CW-1:0] cell_reg;

            // Per-cell register; cell_idx is zero-based here.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    cell_reg <= '0;
                end else if (clr) begin
                    cell_reg <= '0;
                end else if (fill) begin
                    cell_reg <= color;
                end else if (wr_cell && (cell_idx == CIW'(gi))) begin
                    cell_reg <= color;
                end
            end

            assign data[gi*CW +: CW] = cell_reg;
        end
    endgenerate

endmodule

// File: rtl/magic_cube_data_set.sv
// Whole-cube sticker store: command FSM, address validation, per-face
// register banks and the selected-face view.
// Optional build macro MAGIC_CUBE_COMPLETE_EN adds a written-cell mask with
// face_complete / cube_complete outputs.
module magic_cube_data_set
    import magic_cube_pkg::*;
#(
    parameter int FACES = FACES_DEF,
    parameter int CELLS = CELLS_DEF,
    parameter int CW    = CW_DEF,
    parameter int POSW  = 9,
    parameter int FW    = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [1:0]                  op,
    input  logic [FW-1:0]               face_sel,
    input  logic [POSW-1:0]             position_coding,
    input  logic [CW-1:0]               color_coding,
    input  logic [FW-1:0]               view_face,
    output logic [FACES*CELLS*CW-1:0]   cube_dout,
    output logic [CELLS*CW-1:0]         oneside_dout,
    output logic                        busy,
    output logic                        done,
`ifdef MAGIC_CUBE_COMPLETE_EN
    output logic                        err,
    output logic [FACES-1:0]            face_complete,
    output logic                        cube_complete
`else
    output logic                        err
`endif
);

    localparam int CIW = (CELLS > 1) ? $clog2(CELLS) : 1;

    state_t             state_reg;
    op_t                op_reg;
    logic [FW-1:0]      face_reg;
    logic [POSW-1:0]    pos_reg;
    logic [CW-1:0]      color_reg;
    logic               err_pending_reg;

    logic               accept;
    logic               cmd_error;
    logic               apply;
    logic [CIW-1:0]     cell_idx;
    logic [FACES-1:0]   wr_f;
    logic [FACES-1:0]   clr_f;
    logic [FACES-1:0]   fill_f;

    // READY doubles as the re-arm slot so a held enable gives one command
    // every 4 cycles; everywhere else enable is only looked at in IDLE.
    assign accept = enable && ((state_reg == ST_IDLE) || (state_reg == ST_READY));

    // Rejection rule on the captured command; a cube clear never errors.
    always_comb begin
        cmd_error = 1'b0;
        if ((op_reg != OP_CLR_CUBE) && (int'(face_reg) >= FACES)) begin
            cmd_error = 1'b1;
        end
        if ((op_reg == OP_WRITE) &&
            ((pos_reg == '0) || (int'(pos_reg) > CELLS))) begin
            cmd_error = 1'b1;
        end
    end

    // Capture the command fields on accept; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_reg    <= OP_WRITE;
            face_reg  <= '0;
            pos_reg   <= '0;
            color_reg <= '0;
        end else if (accept) begin
            op_reg    <= op_t'(op);
            face_reg  <= face_sel;
            pos_reg   <= position_coding;
            color_reg <= color_coding;
        end
    end

    // Command sequencer with registered busy/done/err.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            err_pending_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        state_reg <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    err_pending_reg <= cmd_error;
                    state_reg       <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    done      <= 1'b1;
                    err       <= err_pending_reg;
                    state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    done      <= 1'b0;
                    state_reg <= ST_READY;
                end
                ST_READY: begin
                    if (accept) begin
                        err       <= 1'b0;
                        state_reg <= ST_LATCH;
                    end else begin
                        busy      <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Storage strobes fire on the same edge that raises done.
    assign apply    = (state_reg == ST_UPDATE) && !err_pending_reg;
    assign cell_idx = CIW'(pos_reg - POSW'(1));

    genvar gi;
    generate
        for (gi = 0; gi < FACES; gi++) begin : g_face
            logic sel;
            assign sel       = (face_reg == FW'(gi));
            assign wr_f[gi]  = apply && (op_reg == OP_WRITE) && sel;
            assign fill_f[gi] = apply && (op_reg == OP_FILL_FACE) && sel;
            assign clr_f[gi] = apply && ((op_reg == OP_CLR_CUBE) ||
                                         ((op_reg == OP_CLR_FACE) && sel));

            magic_face_store #(
                .CELLS (CELLS),
                .CW    (CW),
                .CIW   (CIW)
            ) u_face (
                .clk      (clk),
                .rst      (rst),
                .wr_cell  (wr_f[gi]),
                .clr      (clr_f[gi]),
                .fill     (fill_f[gi]),
                .cell_idx (cell_idx),
                .color    (color_reg),
                .data     (cube_dout[gi*CELLS*CW +: CELLS*CW])
            );
        end
    endgenerate

    // Selected-face view; an out-of-range face shows all zeros.
    always_comb begin
        oneside_dout = '0;
        for (int f = 0; f < FACES; f++) begin
            if (view_face == FW'(f)) begin
                oneside_dout = cube_dout[f*CELLS*CW +: CELLS*CW];
            end
        end
    end

`ifdef MAGIC_CUBE_COMPLETE_EN
    logic [FACES*CELLS-1:0] mask_reg;
    logic [FACES*CELLS-1:0] mask_next;

    // Next written-cell mask, following the same strobes as the storage.
    always_comb begin
        mask_next = mask_reg;
        for (int f = 0; f < FACES; f++) begin
            for (int c = 0; c < CELLS; c++) begin
                if (clr_f[f]) begin
                    mask_next[f*CELLS + c] = 1'b0;
                end else if (fill_f[f]) begin
                    mask_next[f*CELLS + c] = 1'b1;
                end else if (wr_f[f] && (cell_idx == CIW'(c))) begin
                    mask_next[f*CELLS + c] = 1'b1;
                end
            end
        end
    end

    // Mask and completion flags update together with done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mask_reg      <= '0;
            face_complete <= '0;
            cube_complete <= 1'b0;
        end else if (state_reg == ST_UPDATE) begin
            mask_reg      <= mask_next;
            for (int f = 0; f < FACES; f++) begin
                face_complete[f] <= &mask_next[f*CELLS +: CELLS];
            end
            cube_complete <= &mask_next;
        end
    end
`endif

endmodule

// File: tb/tb_magic_cube_data_set.sv
// Self-checking bench for magic_cube_data_set: a command-level model of the
// cube contents and handshake is compared against the DUT every cycle, with
// directed literal checks and a randomized command phase.
module tb_magic_cube_data_set;

    localparam int FACES = 6;
    localparam int CELLS = 9;
    localparam int CW    = 3;
    localparam int TOTW  = FACES*CELLS*CW;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               enable = 1'b0;
    logic [1:0]         op = 2'b00;
    logic [2:0]         face_sel = 3'd0;
    logic [8:0]         position_coding = 9'd0;
    logic [2:0]         color_coding = 3'd0;
    logic [2:0]         view_face = 3'd0;
    logic [TOTW-1:0]    cube_dout;
    logic [CELLS*CW-1:0] oneside_dout;
    logic               busy, done, err;
`ifdef MAGIC_CUBE_COMPLETE_EN
    logic [FACES-1:0]   face_complete;
    logic               cube_complete;
`endif

    magic_cube_data_set dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .op              (op),
        .face_sel        (face_sel),
        .position_coding (position_coding),
        .color_coding    (color_coding),
        .view_face       (view_face),
        .cube_dout       (cube_dout),
        .oneside_dout    (oneside_dout),
        .busy            (busy),
        .done            (done),
`ifdef MAGIC_CUBE_COMPLETE_EN
        .err             (err),
        .face_complete   (face_complete),
        .cube_complete   (cube_complete)
`else
        .err             (err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int pass  = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [2:0] m_cell [FACES][CELLS];
    bit         m_wr   [FACES][CELLS];
    bit         m_active;
    int         m_k;
    int         m_op, m_face, m_pos, m_col;
    bit         m_cmd_err;
    bit         exp_busy, exp_done, exp_err;
    bit         exp_fc [FACES];
    bit         exp_cc;

    // Command advances on cycle counts since accept: data+done at 2, re-arm at 4.
    always @(posedge clk) begin
        if (!rst) begin
            for (int f = 0; f < FACES; f++)
                for (int c = 0; c < CELLS; c++) begin
                    m_cell[f][c] = 3'd0;
                    m_wr[f][c] = 1'b0;
                end
            for (int f = 0; f < FACES; f++) exp_fc[f] = 1'b0;
            exp_cc = 1'b0;
            m_active = 1'b0; m_k = 0;
            exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (m_active) m_k++;
            if (m_active && m_k == 2) begin
                if (!m_cmd_err) begin
                    case (m_op)
                        0: begin m_cell[m_face][m_pos-1] = m_col[2:0]; m_wr[m_face][m_pos-1] = 1'b1; end
                        1: for (int c = 0; c < CELLS; c++) begin m_cell[m_face][c] = 3'd0; m_wr[m_face][c] = 1'b0; end
                        2: for (int f = 0; f < FACES; f++)
                               for (int c = 0; c < CELLS; c++) begin m_cell[f][c] = 3'd0; m_wr[f][c] = 1'b0; end
                        default: for (int c = 0; c < CELLS; c++) begin m_cell[m_face][c] = m_col[2:0]; m_wr[m_face][c] = 1'b1; end
                    endcase
                end
                exp_cc = 1'b1;
                for (int f = 0; f < FACES; f++) begin
                    exp_fc[f] = 1'b1;
                    for (int c = 0; c < CELLS; c++) if (!m_wr[f][c]) exp_fc[f] = 1'b0;
                    if (!exp_fc[f]) exp_cc = 1'b0;
                end
                exp_done = 1'b1;
                exp_err  = m_cmd_err;
            end
            if ((!m_active || m_k == 4) && enable) begin
                m_active = 1'b1; m_k = 0;
                m_op = int'(op); m_face = int'(face_sel);
                m_pos = int'(position_coding); m_col = int'(color_coding);
                m_cmd_err = (m_op != 2 && m_face >= FACES) ||
                            (m_op == 0 && (m_pos == 0 || m_pos > CELLS));
                exp_busy = 1'b1; exp_err = 1'b0;
            end else if (m_active && m_k == 4) begin
                m_active = 1'b0; exp_busy = 1'b0;
            end
        end
    end

    function automatic logic [TOTW-1:0] model_cube();
        logic [TOTW-1:0] v = '0;
        for (int f = 0; f < FACES; f++)
            for (int c = 0; c < CELLS; c++)
                v[(f*CELLS+c)*CW +: CW] = m_cell[f][c];
        return v;
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [TOTW-1:0] mc;
            logic [CELLS*CW-1:0] mo;
            mc = model_cube();
            mo = (int'(view_face) < FACES) ? mc[int'(view_face)*CELLS*CW +: CELLS*CW] : '0;
            check("cube_dout", 256'(cube_dout), 256'(mc));
            check("oneside_dout", 256'(oneside_dout), 256'(mo));
            check("busy", 256'(busy), 256'(exp_busy));
            check("done", 256'(done), 256'(exp_done));
            check("err", 256'(err), 256'(exp_err));
`ifdef MAGIC_CUBE_COMPLETE_EN
            for (int f = 0; f < FACES; f++)
                check("face_complete", 256'(face_complete[f]), 256'(exp_fc[f]));
            check("cube_complete", 256'(cube_complete), 256'(exp_cc));
`endif
        end
    end

    // One directed command; returns done/err sampled two cycles after accept.
    task automatic cmd(input logic [1:0] o, input logic [2:0] f, input logic [8:0] p,
                       input logic [2:0] c, output logic d, output logic e);
        @(negedge clk);
        enable = 1'b1; op = o; face_sel = f; position_coding = p; color_coding = c;
        @(negedge clk);
        enable = 1'b0; op = 2'($urandom); face_sel = 3'($urandom);
        position_coding = 9'($urandom); color_coding = 3'($urandom);
        @(negedge clk);
        @(negedge clk);
        d = done; e = err;
        $display("cmd op=%0d face=%0d pos=%0d col=%0d -> done=%0b err=%0b", o, f, p, c, d, e);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic d, e;
        logic [TOTW-1:0] snap;
        logic [TOTW-1:0] one_hot;
        int cnt;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset cube", 256'(cube_dout), 256'(0));
        check("reset busy", 256'({busy, done, err}), 256'(0));
        rst = 1'b1;
        chk_en = 1'b1;

        // Single write: face 2, pos 5, colour 101.
        cmd(2'b00, 3'd2, 9'd5, 3'b101, d, e);
        check("write done", 256'(d), 256'(1));
        check("write err", 256'(e), 256'(0));
        one_hot = '0;
        one_hot[66 +: 3] = 3'b101;
        check("write bits", 256'(cube_dout), 256'(one_hot));

        // Bad addresses.
        snap = cube_dout;
        cmd(2'b00, 3'd2, 9'd0, 3'b111, d, e);
        check("pos0 err", 256'({d, e}), 256'(2'b11));
        cmd(2'b00, 3'd2, 9'd10, 3'b111, d, e);
        check("pos10 err", 256'({d, e}), 256'(2'b11));
        cmd(2'b11, 3'd6, 9'd1, 3'b111, d, e);
        check("face6 err", 256'({d, e}), 256'(2'b11));
        check("err unchanged", 256'(cube_dout), 256'(snap));

        // Fill then clear face 4.
        view_face = 3'd4;
        cmd(2'b11, 3'd4, 9'd0, 3'b011, d, e);
        check("fill view", 256'(oneside_dout), 256'(27'o333333333));
        check("face3 untouched", 256'(cube_dout[3*27 +: 27]), 256'(0));
        cmd(2'b01, 3'd4, 9'd0, 3'b000, d, e);
        check("clear view", 256'(oneside_dout), 256'(0));

        // Several writes then cube clear with face_sel 7.
        cmd(2'b00, 3'd0, 9'd1, 3'b110, d, e);
        cmd(2'b00, 3'd5, 9'd9, 3'b001, d, e);
        cmd(2'b00, 3'd3, 9'd4, 3'b010, d, e);
        cmd(2'b10, 3'd7, 9'd0, 3'b000, d, e);
        check("cube clr err", 256'(e), 256'(0));
        check("cube clr data", 256'(cube_dout), 256'(0));

        // Held enable for 12 edges: commands at 4-cycle spacing.
        cnt = 0;
        @(negedge clk);
        enable = 1'b1; op = 2'b00; face_sel = 3'd1; position_coding = 9'd3; color_coding = 3'd4;
        repeat (12) begin @(negedge clk); cnt += int'(done); end
        enable = 1'b0;
        repeat (8) begin @(negedge clk); cnt += int'(done); end
        $display("held enable -> %0d completions", cnt);
        check("held enable count", 256'(cnt), 256'(3));

`ifdef MAGIC_CUBE_COMPLETE_EN
        for (int f = 0; f < FACES; f++) cmd(2'b11, 3'(f), 9'd0, 3'(f + 1), d, e);
        check("cube complete", 256'(cube_complete), 256'(1));
        cmd(2'b01, 3'd2, 9'd0, 3'd0, d, e);
        check("cube incomplete", 256'(cube_complete), 256'(0));
`endif

        // Reset during UPDATE discards the command and storage.
        cmd(2'b11, 3'd1, 9'd0, 3'b111, d, e);
        @(negedge clk);
        enable = 1'b1; op = 2'b00; face_sel = 3'd0; position_coding = 9'd1; color_coding = 3'd7;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid reset cube", 256'(cube_dout), 256'(0));
        check("mid reset busy", 256'({busy, done}), 256'(0));
        $display("reset during UPDATE -> busy=%0b done=%0b", busy, done);
        rst = 1'b1;

        // Randomized commands, including enable asserted while busy.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            enable = ($urandom_range(0, 3) == 0);
            op = 2'($urandom);
            face_sel = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            position_coding = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(1, 9));
            color_coding = 3'($urandom);
            view_face = 3'($urandom);
            if (done) $display("rand cycle %0d: done err=%0b", i, err);
        end
        enable = 1'b0;
        repeat (6) @(negedge clk);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
